// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, ex/wb forwarding, load-use stall and a registered operand stage.
// Define OPFETCH_WB_BYPASS_EN to forward the writeback port; without it, a wb hit stalls one cycle.
module operand_fetch (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_we,
  input  logic        in_is_load,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_fwd_en,
  input  logic [4:0]  ex_fwd_addr,
  input  logic [31:0] ex_fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_is_load
);
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

`ifdef OPFETCH_WB_BYPASS_EN
  function automatic word_t select_operand(input addr_t addr, input word_t rf_val,
                                           input logic fe, input addr_t fa, input word_t fd,
                                           input logic we, input addr_t wa, input word_t wd);
    if (addr == '0)              return '0;
    else if (fe && (fa == addr)) return fd;
    else if (we && (wa == addr)) return wd;
    else                         return rf_val;
  endfunction
`else
  function automatic word_t select_operand(input addr_t addr, input word_t rf_val,
                                           input logic fe, input addr_t fa, input word_t fd);
    if (addr == '0)              return '0;
    else if (fe && (fa == addr)) return fd;
    else                         return rf_val;
  endfunction
`endif

  word_t rs1_sel, rs2_sel;
  logic  lu_pending, lu_rd_hit, lu_fwd, lu_set, hazard, accept, xfer;
  addr_t lu_rd;

  logic  vld_p1, rd_we_p1, is_load_p1;
  word_t rs1_val_p1, rs2_val_p1, pc_p1;
  addr_t rd_p1;

  assign rs1_addr = in_rs1;
  assign rs2_addr = in_rs2;

  always_comb begin
`ifdef OPFETCH_WB_BYPASS_EN
    rs1_sel = select_operand(in_rs1, rs1_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                             wb_en, wb_addr, wb_data);
    rs2_sel = select_operand(in_rs2, rs2_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                             wb_en, wb_addr, wb_data);
`else
    rs1_sel = select_operand(in_rs1, rs1_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data);
    rs2_sel = select_operand(in_rs2, rs2_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data);
`endif
  end

  // A pending load result only blocks us until execute forwards it.
  assign lu_rd_hit = lu_pending && (((in_rs1 != '0) && (in_rs1 == lu_rd)) ||
                                    ((in_rs2 != '0) && (in_rs2 == lu_rd)));
  assign lu_fwd    = ex_fwd_en && (ex_fwd_addr == lu_rd);

`ifdef OPFETCH_WB_BYPASS_EN
  assign hazard = lu_rd_hit && !lu_fwd;
`else
  logic wb_hit;
  logic unused_wb_data;
  assign wb_hit         = wb_en && (wb_addr != '0) && ((wb_addr == in_rs1) || (wb_addr == in_rs2));
  assign hazard         = (lu_rd_hit && !lu_fwd) || wb_hit;
  assign unused_wb_data = ^wb_data;
`endif

  assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush && resetn;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld_p1 && out_ready;
  assign lu_set   = xfer && is_load_p1 && rd_we_p1 && (rd_p1 != '0);

  // Stage p1: registered operands handed to execute
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1     <= 1'b0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      pc_p1      <= '0;
      rd_p1      <= '0;
      rd_we_p1   <= 1'b0;
      is_load_p1 <= 1'b0;
      lu_pending <= 1'b0;
      lu_rd      <= '0;
    end else begin
      if (flush)       vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (xfer)   vld_p1 <= 1'b0;

      if (accept) begin
        rs1_val_p1 <= rs1_sel;
        rs2_val_p1 <= rs2_sel;
        pc_p1      <= in_pc;
        rd_p1      <= in_rd;
        rd_we_p1   <= in_rd_we;
        is_load_p1 <= in_is_load;
      end

      // A load leaving this cycle outranks any clear seen in the same cycle.
      if (lu_set) begin
        lu_pending <= 1'b1;
        lu_rd      <= rd_p1;
      end else if (flush || lu_fwd) begin
        lu_pending <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_rs1_val = rs1_val_p1;
  assign out_rs2_val = rs2_val_p1;
  assign out_pc      = pc_p1;
  assign out_rd      = rd_p1;
  assign out_rd_we   = rd_we_p1;
  assign out_is_load = is_load_p1;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed corner cases followed by randomized traffic.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we, in_is_load;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_fwd_en;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_is_load;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_pc(out_pc),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load)
  );

  // Behavioural register file written by the writeback port.
  logic [31:0] rf [32];
  logic        force_junk;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 | 32'(i);
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign rs1_data = force_junk ? 32'hDEADBEEF : ((rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr]);
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
  } rec_t;

  rec_t       q[$];
  logic       mlu;
  logic [4:0] mlurd;

  // Operand value as the architecture defines it for the current cycle.
  function automatic logic [31:0] pick(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ex_fwd_en && ex_fwd_addr == a) return ex_fwd_data;
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return rf[a];
  endfunction

  // Monitor: samples mid-cycle, checks the DUT, then advances the reference model.
  always @(negedge clk) begin
    rec_t r;
    logic hz, er, xfer, acc, lset;
    if (!resetn) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_rs1_val | out_rs2_val | out_pc | 32'({out_rd, out_rd_we, out_is_load}), 32'd0);
      q.delete();
      mlu = 1'b0;
      mlurd = 5'd0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_rs1_val", out_rs1_val, q[0].a);
        chk("out_rs2_val", out_rs2_val, q[0].b);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_ctl", 32'({out_rd, out_rd_we, out_is_load}), 32'({q[0].rd, q[0].we, q[0].ld}));
      end
      hz = mlu && ((in_rs1 != 5'd0 && in_rs1 == mlurd) || (in_rs2 != 5'd0 && in_rs2 == mlurd))
           && !(ex_fwd_en && ex_fwd_addr == mlurd);
`ifndef OPFETCH_WB_BYPASS_EN
      hz = hz || (wb_en && wb_addr != 5'd0 && (wb_addr == in_rs1 || wb_addr == in_rs2));
`endif
      er = (q.size() == 0 || out_ready) && !hz && !flush;
      chk("in_ready", 32'(in_ready), 32'(er));
      xfer = (q.size() > 0) && out_ready;
      acc  = in_valid && er;
      lset = 1'b0;
      if (xfer) begin
        r = q.pop_front();
        lset = r.ld && r.we && (r.rd != 5'd0);
      end
      if (flush) q.delete();
      if (lset) begin
        mlu = 1'b1;
        mlurd = r.rd;
      end else if (flush || (ex_fwd_en && ex_fwd_addr == mlurd)) begin
        mlu = 1'b0;
      end
      if (acc) begin
        r.a  = pick(in_rs1);
        r.b  = pick(in_rs2);
        r.pc = in_pc;
        r.rd = in_rd;
        r.we = in_rd_we;
        r.ld = in_is_load;
        q.push_back(r);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rd_we = 1'b0; in_is_load = 1'b0; in_pc = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ex_fwd_en = 1'b0; ex_fwd_addr = 5'd0; ex_fwd_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic [31:0] pc);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_is_load = ld; in_pc = pc;
  endtask

  // Hold in_valid until accepted; writeback pulses are one-shot.
  task automatic issue(input int budget);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      wb_en = 1'b0;
    end
    in_valid = 1'b0;
    chk("issue_accept", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    idle();
    force_junk = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // x0 always reads zero, even against junk regfile data and an x0 forward
    force_junk = 1'b1;
    set_inst(5'd0, 5'd3, 5'd1, 1'b1, 1'b0, 32'h10);
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd0; ex_fwd_data = 32'h1234;
    issue(4);
    force_junk = 1'b0; ex_fwd_en = 1'b0;
    chk("x0_read", out_rs1_val, 32'd0);

    // forwarding priority on rs2 = x5
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h33;
    tick();
    wb_en = 1'b0;
    set_inst(5'd0, 5'd5, 5'd2, 1'b1, 1'b0, 32'h20);
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd5; ex_fwd_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h22;
    issue(4);
    ex_fwd_en = 1'b0;
    chk("prio_ex", out_rs2_val, 32'h11);
    set_inst(5'd0, 5'd5, 5'd2, 1'b1, 1'b0, 32'h24);
`ifdef OPFETCH_WB_BYPASS_EN
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h22;
    issue(4);
    chk("prio_wb", out_rs2_val, 32'h22);
`else
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h33;
    in_valid = 1'b1;
    #1;
    chk("wb_stall", 32'(in_ready), 32'd0);
    issue(4);
    chk("prio_rf", out_rs2_val, 32'h33);
`endif

    // load-use stall released by the execute forward
    flush = 1'b1; tick(); flush = 1'b0;
    set_inst(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h40);
    issue(4);
    tick();
    set_inst(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h44);
    in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("lu_stall", 32'(in_ready), 32'd0);
      tick();
    end
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd7; ex_fwd_data = 32'hCAFE;
    issue(4);
    ex_fwd_en = 1'b0;
    chk("lu_fwd_val", out_rs1_val, 32'hCAFE);

    // flush during a load-use stall
    set_inst(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h50);
    issue(4);
    tick();
    set_inst(5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 32'h54);
    in_valid = 1'b1;
    tick();
    #1;
    chk("flush_pre_stall", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    #1;
    chk("flush_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("flush_accept_pc", out_pc, 32'h54);

    // backpressure then full-rate stream
    set_inst(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h100);
    issue(4);
    out_ready = 1'b0;
    set_inst(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h104);
    in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_pc", out_pc, 32'h100);
      tick();
    end
    out_ready = 1'b1;
    base = n_acc;
    for (int i = 0; i < 8; i++) begin
      set_inst(5'd0, 5'd0, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 32'h104 + 32'(4 * i));
      tick();
    end
    in_valid = 1'b0;
    chk("stream_rate", 32'(n_acc - base), 32'd8);
    tick();

    // asynchronous reset while an instruction is held
    set_inst(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h200);
    out_ready = 1'b0;
    issue(4);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      set_inst(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom);
      wb_en       = ($urandom_range(0, 2) == 0);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      ex_fwd_en   = ($urandom_range(0, 2) == 0);
      ex_fwd_addr = 5'($urandom_range(0, 7));
      ex_fwd_data = $urandom;
      flush       = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
